// File: rtl/sdc_resp_rcv.sv
// SD CMD-line response receiver: hunts the start bit, shifts in a 48/136-bit response,
// checks CRC7, index, framing and no-response timeout, then reports with a one-clock strobe.
module sdc_resp_rcv #(
    parameter int unsigned     TO_W    = 8,
    parameter logic [TO_W-1:0] NCR_MAX = TO_W'(64)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_strb,
    input  logic         bit_en,
    input  logic         cmd_in,
    input  logic         long_resp,
    input  logic         skip_crc,
    input  logic [5:0]   exp_index,
    output logic         busy,
    output logic         resp_strb,
    output logic [135:0] resp_packet,
    output logic [5:0]   resp_index,
    output logic [31:0]  resp_arg,
    output logic         crc_err,
    output logic         index_err,
    output logic         frame_err,
    output logic         timeout_err
);

    localparam int unsigned PKT_W = 136;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned CRC_W = 7;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned ARG_W = 32;

    localparam logic [CNT_W-1:0] SHORT_LEN = CNT_W'(48);
    localparam logic [CNT_W-1:0] LONG_LEN  = CNT_W'(136);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        RECEIVE,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic               long_q, long_d;
    logic               skip_q, skip_d;
    logic [IDX_W-1:0]   exp_idx_q, exp_idx_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CRC_W-1:0]   crc_q, crc_d;
    logic [PKT_W-1:0]   shift_q, shift_d;
    logic               tmo_q, tmo_d;

    logic               busy_q, busy_d;
    logic               strb_q, strb_d;
    logic [PKT_W-1:0]   pkt_q, pkt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ARG_W-1:0]   arg_q, arg_d;
    logic               crc_err_q, crc_err_d;
    logic               idx_err_q, idx_err_d;
    logic               frm_err_q, frm_err_d;
    logic               tmo_err_q, tmo_err_d;

    logic [CNT_W-1:0]   nxt_cnt_c;
    logic [IDX_W-1:0]   rx_index_c;
    logic               trans_bit_c;
    logic [CNT_W-1:0]   last_len_c;

    // Serial CRC7, generator x^7 + x^3 + 1
    function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[CRC_W-1];
        return {crc[CRC_W-2:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    // Bit k (1-based, start bit = 1) contributes to the CRC
    function automatic logic crc_covers(input logic lng, input logic [CNT_W-1:0] k);
        return lng ? ((k >= CNT_W'(9)) && (k <= CNT_W'(128))) : (k <= CNT_W'(40));
    endfunction

    always_comb begin
        state_d     = state_q;
        long_d      = long_q;
        skip_d      = skip_q;
        exp_idx_d   = exp_idx_q;
        to_cnt_d    = to_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        crc_d       = crc_q;
        shift_d     = shift_q;
        tmo_d       = tmo_q;
        busy_d      = busy_q;
        strb_d      = 1'b0;
        pkt_d       = pkt_q;
        idx_d       = idx_q;
        arg_d       = arg_q;
        crc_err_d   = crc_err_q;
        idx_err_d   = idx_err_q;
        frm_err_d   = frm_err_q;
        tmo_err_d   = tmo_err_q;
        nxt_cnt_c   = bit_cnt_q + CNT_W'(1);
        last_len_c  = long_q ? LONG_LEN : SHORT_LEN;
        rx_index_c  = long_q ? shift_q[133:128] : shift_q[45:40];
        trans_bit_c = long_q ? shift_q[134] : shift_q[46];

        // Arming wins in every state; an in-flight reception is dropped without a strobe
        if (start_strb) begin
            long_d    = long_resp;
            skip_d    = skip_crc;
            exp_idx_d = exp_index;
            to_cnt_d  = '0;
            bit_cnt_d = '0;
            crc_d     = '0;
            shift_d   = '0;
            tmo_d     = 1'b0;
            busy_d    = 1'b1;
            pkt_d     = '0;
            idx_d     = '0;
            arg_d     = '0;
            crc_err_d = 1'b0;
            idx_err_d = 1'b0;
            frm_err_d = 1'b0;
            tmo_err_d = 1'b0;
            state_d   = WAIT_START;
        end else begin
            case (state_q)
                IDLE: begin
                end
                WAIT_START: begin
                    if (bit_en) begin
                        if (!cmd_in) begin
                            shift_d   = {shift_q[PKT_W-2:0], cmd_in};
                            crc_d     = crc_covers(long_q, CNT_W'(1)) ? crc7_step(crc_q, cmd_in) : crc_q;
                            bit_cnt_d = CNT_W'(1);
                            state_d   = RECEIVE;
                        end else if (to_cnt_q == NCR_MAX - TO_W'(1)) begin
                            tmo_d   = 1'b1;
                            state_d = DONE;
                        end else begin
                            to_cnt_d = to_cnt_q + TO_W'(1);
                        end
                    end
                end
                RECEIVE: begin
                    if (bit_en) begin
                        shift_d   = {shift_q[PKT_W-2:0], cmd_in};
                        crc_d     = crc_covers(long_q, nxt_cnt_c) ? crc7_step(crc_q, cmd_in) : crc_q;
                        bit_cnt_d = nxt_cnt_c;
                        if (nxt_cnt_c == last_len_c) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    busy_d  = 1'b0;
                    strb_d  = 1'b1;
                    state_d = IDLE;
                    if (tmo_q) begin
                        pkt_d     = '0;
                        idx_d     = '0;
                        arg_d     = '0;
                        crc_err_d = 1'b0;
                        idx_err_d = 1'b0;
                        frm_err_d = 1'b0;
                        tmo_err_d = 1'b1;
                    end else begin
                        pkt_d     = shift_q;
                        idx_d     = rx_index_c;
                        arg_d     = long_q ? '0 : shift_q[39:8];
                        crc_err_d = !skip_q && (crc_q != shift_q[7:1]);
                        idx_err_d = !long_q && !skip_q && (rx_index_c != exp_idx_q);
                        frm_err_d = trans_bit_c || !shift_q[0];
                        tmo_err_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            long_q    <= 1'b0;
            skip_q    <= 1'b0;
            exp_idx_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            crc_q     <= '0;
            shift_q   <= '0;
            tmo_q     <= 1'b0;
            busy_q    <= 1'b0;
            strb_q    <= 1'b0;
            pkt_q     <= '0;
            idx_q     <= '0;
            arg_q     <= '0;
            crc_err_q <= 1'b0;
            idx_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            long_q    <= long_d;
            skip_q    <= skip_d;
            exp_idx_q <= exp_idx_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            crc_q     <= crc_d;
            shift_q   <= shift_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
            strb_q    <= strb_d;
            pkt_q     <= pkt_d;
            idx_q     <= idx_d;
            arg_q     <= arg_d;
            crc_err_q <= crc_err_d;
            idx_err_q <= idx_err_d;
            frm_err_q <= frm_err_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign busy        = busy_q;
    assign resp_strb   = strb_q;
    assign resp_packet = pkt_q;
    assign resp_index  = idx_q;
    assign resp_arg    = arg_q;
    assign crc_err     = crc_err_q;
    assign index_err   = idx_err_q;
    assign frame_err   = frm_err_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_sdc_resp_rcv.sv
// Bench for sdc_resp_rcv: directed vector table, abort sequences, and randomized frames
// checked against a polynomial-division reference model.
module tb_sdc_resp_rcv;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start_strb = 1'b0;
    logic         bit_en = 1'b0;
    logic         cmd_in = 1'b1;
    logic         long_resp = 1'b0;
    logic         skip_crc = 1'b0;
    logic [5:0]   exp_index = '0;
    logic         busy;
    logic         resp_strb;
    logic [135:0] resp_packet;
    logic [5:0]   resp_index;
    logic [31:0]  resp_arg;
    logic         crc_err;
    logic         index_err;
    logic         frame_err;
    logic         timeout_err;

    int n_chk = 0;
    int n_err = 0;
    int strb_seen = 0;
    int strb_exp = 0;

    sdc_resp_rcv dut (
        .clk        (clk),
        .reset      (reset),
        .start_strb (start_strb),
        .bit_en     (bit_en),
        .cmd_in     (cmd_in),
        .long_resp  (long_resp),
        .skip_crc   (skip_crc),
        .exp_index  (exp_index),
        .busy       (busy),
        .resp_strb  (resp_strb),
        .resp_packet(resp_packet),
        .resp_index (resp_index),
        .resp_arg   (resp_arg),
        .crc_err    (crc_err),
        .index_err  (index_err),
        .frame_err  (frame_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (resp_strb === 1'b1) strb_seen++;

    typedef struct {
        logic [135:0] pkt;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic         crc, ierr, ferr, tmo;
    } exp_t;

    typedef struct {
        logic         lng, skip, arm_be;
        logic [5:0]   eidx;
        logic [135:0] frame;
        int           idle;
        logic [5:0]   x_idx;
        logic [31:0]  x_arg;
        logic         x_crc, x_ierr, x_ferr, x_tmo;
    } vec_t;

    // Remainder of msg(x) * x^7 divided by x^7 + x^3 + 1 (0x89), msg holds n bits right-aligned
    function automatic logic [6:0] ref_crc(input logic [135:0] msg, input int n);
        logic [142:0] r;
        r = {msg, 7'b0};
        for (int i = n + 6; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    function automatic exp_t ref_model(input logic lng, input logic skip, input logic [5:0] eidx,
                                       input logic [135:0] frame, input int idle);
        exp_t e;
        logic [135:0] msg;
        logic trans;
        int clen;
        e = '{pkt: '0, idx: '0, arg: '0, crc: 1'b0, ierr: 1'b0, ferr: 1'b0, tmo: 1'b0};
        if (idle >= 64) begin
            e.tmo = 1'b1;
            return e;
        end
        e.pkt = frame;
        if (lng) begin
            e.idx = frame[133:128];
            trans = frame[134];
            msg   = 136'(frame[127:8]);
            clen  = 120;
        end else begin
            e.idx = frame[45:40];
            e.arg = frame[39:8];
            trans = frame[46];
            msg   = 136'(frame[47:8]);
            clen  = 40;
        end
        e.crc  = !skip && (ref_crc(msg, clen) != frame[7:1]);
        e.ierr = !lng && !skip && (e.idx != eidx);
        e.ferr = trans || !frame[0];
        return e;
    endfunction

    function automatic vec_t mkvec(input logic lng, input logic skip, input logic arm_be, input logic [5:0] eidx,
                                   input logic [135:0] frame, input int idle, input logic [5:0] x_idx,
                                   input logic [31:0] x_arg, input logic x_crc, input logic x_ierr,
                                   input logic x_ferr, input logic x_tmo);
        vec_t v;
        v.lng = lng; v.skip = skip; v.arm_be = arm_be; v.eidx = eidx; v.frame = frame; v.idle = idle;
        v.x_idx = x_idx; v.x_arg = x_arg; v.x_crc = x_crc; v.x_ierr = x_ierr; v.x_ferr = x_ferr; v.x_tmo = x_tmo;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic arm(input logic lng, input logic skip, input logic [5:0] eidx, input logic be);
        start_strb = 1'b1;
        long_resp  = lng;
        skip_crc   = skip;
        exp_index  = eidx;
        bit_en     = be;
        cmd_in     = !be;
        tick();
        start_strb = 1'b0;
        bit_en     = 1'b0;
        cmd_in     = 1'b1;
        long_resp  = !lng;
        skip_crc   = !skip;
        exp_index  = ~eidx;
    endtask

    task automatic send_bit(input logic b, input int gap);
        int g;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        for (int i = 0; i < g; i++) begin
            cmd_in = 1'($urandom);
            tick();
        end
        cmd_in = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        cmd_in = 1'($urandom);
    endtask

    task automatic check_fields(input string nm, input exp_t e);
        chk({nm, "/packet"}, resp_packet, e.pkt);
        chk({nm, "/index"}, 136'(resp_index), 136'(e.idx));
        chk({nm, "/arg"}, 136'(resp_arg), 136'(e.arg));
        chk({nm, "/crc_err"}, 136'(crc_err), 136'(e.crc));
        chk({nm, "/index_err"}, 136'(index_err), 136'(e.ierr));
        chk({nm, "/frame_err"}, 136'(frame_err), 136'(e.ferr));
        chk({nm, "/timeout_err"}, 136'(timeout_err), 136'(e.tmo));
    endtask

    task automatic run_frame(input string nm, input logic lng, input logic skip, input logic [5:0] eidx,
                             input logic [135:0] frame, input int idle, input logic arm_be,
                             input int gap, input exp_t e);
        int nb;
        int nidle;
        nb    = lng ? 136 : 48;
        nidle = (idle >= 64) ? 64 : idle;
        arm(lng, skip, eidx, arm_be);
        chk({nm, "/busy_arm"}, 136'(busy), 136'(1));
        for (int i = 0; i < nidle; i++) send_bit(1'b1, gap);
        if (idle < 64)
            for (int i = nb - 1; i >= 0; i--) send_bit(frame[i], gap);
        chk({nm, "/strb_early"}, 136'(resp_strb), 136'(0));
        chk({nm, "/busy_pre"}, 136'(busy), 136'(1));
        tick();
        chk({nm, "/strb_lat"}, 136'(resp_strb), 136'(1));
        chk({nm, "/busy_done"}, 136'(busy), 136'(0));
        check_fields(nm, e);
        strb_exp++;
        tick();
        chk({nm, "/strb_width"}, 136'(resp_strb), 136'(0));
        chk({nm, "/hold"}, resp_packet, e.pkt);
    endtask

    vec_t vecs[10];

    initial begin
        logic [135:0] r1, r2;
        logic [119:0] cid;
        exp_t e;
        int s0;

        r1  = 136'(48'h11_0000_0900_67);
        cid = 120'h03_5344_5344_3136_4780_1234_5678_0146;
        r2  = {8'h3F, cid, 8'h01};
        r2[7:1] = ref_crc(136'(cid), 120);

        vecs[0] = mkvec(0, 0, 0, 6'd17, r1, 5, 6'h11, 32'h0000_0900, 0, 0, 0, 0);
        vecs[1] = mkvec(0, 0, 0, 6'd17, 136'(48'h11_0000_0900_65), 5, 6'h11, 32'h0000_0900, 1, 0, 0, 0);
        vecs[2] = mkvec(0, 0, 0, 6'd17, r1, 64, 6'h00, 32'h0, 0, 0, 0, 1);
        vecs[3] = mkvec(1, 0, 0, 6'd2, r2, 5, 6'h3F, 32'h0, 0, 0, 0, 0);
        vecs[4] = mkvec(0, 1, 0, 6'd0, 136'(48'h7F_00FF_8000_FF), 5, 6'h3F, 32'h00FF_8000, 0, 0, 1, 0);
        vecs[5] = mkvec(0, 0, 0, 6'd18, r1, 5, 6'h11, 32'h0000_0900, 0, 1, 0, 0);
        vecs[6] = mkvec(0, 0, 0, 6'd17, 136'(48'h11_0000_0900_66), 5, 6'h11, 32'h0000_0900, 0, 0, 1, 0);
        vecs[7] = mkvec(0, 0, 0, 6'd17, r1, 63, 6'h11, 32'h0000_0900, 0, 0, 0, 0);
        vecs[8] = mkvec(0, 0, 1, 6'd17, r1, 5, 6'h11, 32'h0000_0900, 0, 0, 0, 0);
        vecs[9] = mkvec(0, 1, 0, 6'd5, 136'(48'h3F_00FF_8000_FF), 5, 6'h3F, 32'h00FF_8000, 0, 0, 0, 0);

        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst/busy", 136'(busy), 136'(0));
        chk("rst/strb", 136'(resp_strb), 136'(0));
        e = '{pkt: '0, idx: '0, arg: '0, crc: 1'b0, ierr: 1'b0, ferr: 1'b0, tmo: 1'b0};
        check_fields("rst", e);

        foreach (vecs[k]) begin
            e.tmo  = vecs[k].x_tmo;
            e.pkt  = vecs[k].x_tmo ? 136'(0) : vecs[k].frame;
            e.idx  = vecs[k].x_idx;
            e.arg  = vecs[k].x_arg;
            e.crc  = vecs[k].x_crc;
            e.ierr = vecs[k].x_ierr;
            e.ferr = vecs[k].x_ferr;
            run_frame($sformatf("vec%0d", k), vecs[k].lng, vecs[k].skip, vecs[k].eidx, vecs[k].frame,
                      vecs[k].idle, vecs[k].arm_be, 3, e);
        end

        // Reset in the middle of a reception
        arm(0, 0, 6'd17, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 3);
        for (int i = 47; i >= 28; i--) send_bit(r1[i], 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_rst/busy", 136'(busy), 136'(0));
        chk("abort_rst/packet", resp_packet, 136'(0));
        s0 = strb_seen;
        for (int i = 27; i >= 0; i--) send_bit(r1[i], 3);
        tick(); tick(); tick();
        chk("abort_rst/no_strb", 136'(strb_seen), 136'(s0));
        run_frame("abort_rst/next", 0, 0, 6'd17, r1, 5, 0, 3, ref_model(0, 0, 6'd17, r1, 5));

        // Re-arm while receiving: first frame silently dropped
        s0 = strb_seen;
        arm(0, 0, 6'd17, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 3);
        for (int i = 47; i >= 18; i--) send_bit(vecs[1].frame[i], 3);
        run_frame("rearm/next", 0, 0, 6'd17, r1, 2, 0, 3, ref_model(0, 0, 6'd17, r1, 2));
        chk("rearm/one_strb", 136'(strb_seen), 136'(s0 + 1));

        // Randomized frames against the reference model
        for (int t = 0; t < 40; t++) begin
            logic lng, skip, abe;
            logic [5:0] eidx;
            logic [135:0] fr;
            logic [127:0] rnd;
            int idle, kind, err;
            lng  = 1'($urandom);
            skip = ($urandom_range(0, 3) == 0);
            abe  = 1'($urandom);
            rnd  = {$urandom, $urandom, $urandom, $urandom};
            if (lng) begin
                fr = {8'h3F, rnd[119:0], 8'h01};
                fr[7:1] = ref_crc(136'(fr[127:8]), 120);
            end else begin
                fr = 136'({2'b00, rnd[37:0], 8'h01});
                fr[7:1] = ref_crc(136'(fr[47:8]), 40);
            end
            err = $urandom_range(0, 6);
            case (err)
                0: fr[$urandom_range(1, 7)] ^= 1'b1;
                1: fr[lng ? 134 : 46] = 1'b1;
                2: fr[0] = 1'b0;
                3: fr[$urandom_range(8, lng ? 127 : 45)] ^= 1'b1;
                default: ;
            endcase
            eidx = ($urandom_range(0, 1) == 0) ? fr[45:40] : 6'($urandom);
            kind = $urandom_range(0, 9);
            idle = (kind == 0) ? 64 : (kind == 1) ? 63 : int'($urandom_range(0, 8));
            run_frame($sformatf("rnd%0d", t), lng, skip, eidx, fr, idle, abe, -1,
                      ref_model(lng, skip, eidx, fr, idle));
        end

        tick(); tick();
        chk("total_strobes", 136'(strb_seen), 136'(strb_exp));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
        $fatal(1);
    end

endmodule

// File: doc/sdc_resp_rcv.md
Name: sdc_resp_rcv

Overview:
- Receiver for the SD CMD-line response path; it is the inbound counterpart of the command-packet builder.
- After a command is sent, the block is armed. It then hunts for the response start bit on the serial CMD line and shifts in a 48-bit (R1/R1b/R3/R6/R7) or 136-bit (R2) response.
- It checks start, transmission, index, CRC7 and end bits, with a no-response timeout.
- It presents the decoded fields and error flags to the host-controller register block with a one-clock strobe.

Parameters:
- NCR_MAX, 8'd64: maximum SD bit-times from arm to start bit before a timeout.
- TO_W, 8: width of the timeout counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start_strb  input  1  one-clock pulse that arms the receiver; issued once the command end bit has left
- bit_en  input  1  one-clock qualifier; cmd_in is sampled only in cycles where bit_en=1 (one per SD clock)
- cmd_in  input  1  serial CMD line, MSB first
- long_resp  input  1  1 = 136-bit R2 response; sampled at start_strb
- skip_crc  input  1  1 = R3 (no CRC/index check); sampled at start_strb
- exp_index  input  6  expected command index (command[13:8]); sampled at start_strb
- busy  output  1  high from arm until resp_strb
- resp_strb  output  1  one-clock pulse; all outputs below are valid from this cycle
- resp_packet  output  136  received bits, right-aligned; 48-bit responses occupy [47:0], upper bits 0
- resp_index  output  6  received bits [45:40] (48-bit) or [133:128] (R2)
- resp_arg  output  32  received bits [39:8]; 0 for R2
- crc_err  output  1  computed CRC7 differs from received CRC7
- index_err  output  1  resp_index differs from exp_index (48-bit, skip_crc=0 only)
- frame_err  output  1  transmission bit is not 0, or end bit is not 1
- timeout_err  output  1  no start bit within NCR_MAX bit-times

Behaviour:
- Reset values:
  - busy, resp_strb and all error flags are 0.
  - resp_packet, resp_index and resp_arg are 0.
  - State is IDLE.
- Reset mid-operation aborts immediately to IDLE with no strobe.
- FSM states: IDLE, WAIT_START, RECEIVE, DONE.
  - IDLE: on start_strb, latch long_resp, skip_crc and exp_index; clear error flags; clear the timeout counter; reset the CRC to 0; set busy; go to WAIT_START.
  - WAIT_START: on each bit_en, if cmd_in=0 this is the start bit. Shift it in, set bit count to 1, go to RECEIVE. Otherwise increment the timeout counter. If the counter reaches NCR_MAX-1 with cmd_in still 1, set timeout_err and go to DONE.
  - RECEIVE: on each bit_en, shift cmd_in into resp_packet LSB and increment the bit count. When the count reaches 48 (or 136 if long_resp), go to DONE.
  - DONE: lasts one cycle. Register the fields and flags, pulse resp_strb, clear busy, go to IDLE.
- Latency:
  - resp_strb is high in the clk cycle after the DONE entry, i.e. 2 clocks after the bit_en cycle that sampled the end bit.
  - For a timeout, resp_strb follows the same 2-clock rule, counted from the last timeout sample.
- CRC7:
  - Polynomial x^7+x^3+1, initial value 0, serial and bit-enabled by bit_en.
  - 48-bit responses: CRC covers received bits 1..40 (start through argument end) and is compared with bits 41..47.
  - R2: CRC covers bits 9..128 (after the 8-bit header) and is compared with bits 129..135.
  - skip_crc=1: crc_err and index_err are forced to 0.
- Frame checks:
  - Transmission bit is received bit 2 and must be 0.
  - End bit is the last bit and must be 1.
  - Either violation sets frame_err.
- Output retention:
  - Outputs hold their values until the next start_strb.
  - On a timeout, resp_packet holds 0.
- start_strb while busy re-arms: the current reception is discarded, there is no strobe for it, and the block restarts at WAIT_START.
- Simultaneous start_strb and bit_en in the arm cycle: that bit is ignored; hunting starts at the next bit_en.
- bit_en=0 stalls all counters and the CRC, in any state.

Test Plan:
- R1 nominal: arm with exp_index=17, feed 0x11_00_00_09_00_67 on cmd_in (bit_en every 4 clk), start bit after 5 idle 1s → resp_strb 2 clk after the end bit; resp_index=0x11, resp_arg=0x00000900, all error flags 0.
- CRC fault: same frame with last byte 0x65 → crc_err=1; index_err=0 and frame_err=0.
- Timeout: arm and hold cmd_in=1 → after 64 bit_en samples, timeout_err=1 and resp_strb pulses once; busy=0 afterwards.
- R2: arm with long_resp=1 and feed a 136-bit CID with a valid CRC7 over bits 9..128 → crc_err=0, resp_packet equals the stimulus, resp_arg=0.
- R3 plus frame error: skip_crc=1 and frame 0x3F_00FF8000_FF with transmission bit forced to 1 → frame_err=1, crc_err=0, index_err=0.
- Abort: assert reset at bit 20 of a reception → busy=0 next clock and no resp_strb; a new arm then receives correctly. start_strb at bit 30 → that reception produces no strobe, and the following frame decodes with correct values.
